acs_path_metric_unit: RTL and testbench
=======================================

Name: acs_path_metric_unit

Overview:
- Add-Compare-Select stage of the rate-1/2, K=3 (generators 7,5 octal) hard-decision Viterbi decoder.
- Sits directly downstream of Branch_metric_unit and consumes its four 2-bit branch metrics each symbol.
- Per symbol it updates four registered path metrics (PMs) and emits one survivor decision bit per state to the traceback stage.
- Also reports the current best (minimum-PM) state; PMs are renormalised so they never overflow.

Parameters:
- PM_W, 6, path metric width in bits; minimum 5.
- PM_INIT, 4, initial metric loaded into states 1..3 at reset or frame start; must be < 2^(PM_W-1).

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  frame start; reload initial metrics.
- i_valid  input  1  branch metrics valid this cycle.
- i_BM_0  input  2  Hamming distance of received pair to codeword 00.
- i_BM_1  input  2  Hamming distance to codeword 01.
- i_BM_2  input  2  Hamming distance to codeword 10.
- i_BM_3  input  2  Hamming distance to codeword 11.
- o_valid  output  1  outputs updated this cycle.
- o_dec  output  4  survivor decision per state; bit n is state n.
- o_PM_0..o_PM_3  output  PM_W each  registered path metrics.
- o_best_state  output  2  index of minimum PM.

Behaviour:
- State encoding: s = {u[n-1], u[n-2]}. Next state ns = {u, s[1]}. Codeword is {c0,c1}, with c0 = u^s1^s0 and c1 = u^s0.
- Predecessors of ns: lower p0 = {ns[0],0}, upper p1 = {ns[0],1}.
- Branch metric used by each transition:
  - ns0: p0=0 uses BM_0; p1=1 uses BM_3.
  - ns1: p0=2 uses BM_2; p1=3 uses BM_1.
  - ns2: p0=0 uses BM_3; p1=1 uses BM_0.
  - ns3: p0=2 uses BM_1; p1=3 uses BM_2.
- ACS, when i_valid=1:
  - cand0 = PM[p0] + BM and cand1 = PM[p1] + BM, both computed at PM_W+1 bits.
  - new = min(cand0, cand1). dec[ns] = 1 only if cand1 < cand0 strictly; a tie selects p0 (dec=0).
- Normalisation: if all four new metrics are ≥ 2^(PM_W-1), subtract 2^(PM_W-1) from all four in the same cycle. Results are stored at PM_W bits.
- Latency is 1 cycle. Outputs register on the i_clk edge where i_valid=1, and o_valid is asserted for that following cycle.
- When i_valid=0: PMs, o_dec and o_best_state hold; o_valid=0.
- o_best_state: state with the minimum registered PM; ties go to the lowest index. It is registered together with the PMs and is consistent with them in every cycle.
- i_start with i_valid=0: the next edge loads PM={0,PM_INIT,PM_INIT,PM_INIT}, o_dec=0, o_best_state=0, o_valid=0.
- i_start with i_valid=1 on the same edge: ACS uses {0,PM_INIT,PM_INIT,PM_INIT} as the old PMs (the first symbol of the new frame), and o_valid=1 the next cycle.
- Reset (async, any time, including mid-frame): o_PM_0=0, o_PM_1..3=PM_INIT, o_dec=0, o_best_state=0, o_valid=0. The first edge after deassertion behaves normally.
- No input handshake/backpressure: every i_valid cycle is consumed.

Test Plan:
- Reset, then i_valid=1 with BMs for received 00 (0,1,1,2): next cycle o_valid=1, PM={0,5,2,5}, o_dec=0000, o_best_state=0. A second identical symbol gives PM={0,3,2,3}, o_dec=0000.
- Reset, then one symbol with BMs for received 11 (2,1,1,0): PM={2,5,0,5}, o_dec=0000, best=2. This checks tie→p0 on ns1 and ns3.
- Stall:
  - Sequence: valid, idle 3 cycles, valid.
  - Required: PMs/o_dec/best hold during the idle cycles.
  - Required: o_valid pulses exactly twice, one cycle each.
- Normalisation: hold all BMs=3 with i_valid=1 for 40 cycles.
  - Required: no PM ever exceeds 2^PM_W-1.
  - Required: pairwise PM differences match an unbounded reference model every cycle.
  - Required: at least one normalisation event (all new ≥32 → subtract 32) is observed.
- Start collision:
  - Stimulus: run 5 random symbols, then assert i_start together with an 00 symbol (0,1,1,2).
  - Required: PM={0,5,2,5}, matching the post-reset result.
  - Also: i_start alone gives PM={0,4,4,4}, o_valid=0.
- Async reset mid-frame: assert i_rst_n=0 between clock edges → outputs clear immediately to reset values without waiting for a clock edge. Random-stimulus scoreboard against a C/SV reference ACS model for 1000 symbols.

Source files
------------

// File: rtl/acs_path_metric_unit.sv
// Add-Compare-Select stage for the rate-1/2, K=3 (7,5) hard-decision Viterbi decoder.
// Keeps four renormalised path metrics, per-state survivor decisions and the best state.
module acs_path_metric_unit #(
   parameter int PM_W    = 6,
   parameter int PM_INIT = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_valid,
   input  logic [1:0]      i_BM_0,
   input  logic [1:0]      i_BM_1,
   input  logic [1:0]      i_BM_2,
   input  logic [1:0]      i_BM_3,
   output logic            o_valid,
   output logic [3:0]      o_dec,
   output logic [PM_W-1:0] o_PM_0,
   output logic [PM_W-1:0] o_PM_1,
   output logic [PM_W-1:0] o_PM_2,
   output logic [PM_W-1:0] o_PM_3,
   output logic [1:0]      o_best_state
);

   // Handshake: there is no ready. Every cycle with i_valid=1 is consumed on that
   // edge; o_valid is high for exactly the one cycle after each consumed symbol.

   localparam logic [PM_W:0]   HALF = {2'b01, {(PM_W-1){1'b0}}};
   localparam logic [PM_W-1:0] INIT = PM_W'(PM_INIT);

   logic [PM_W-1:0] pm_q    [4];
   logic [PM_W-1:0] old_pm  [4];
   logic [PM_W:0]   cand0   [4];
   logic [PM_W:0]   cand1   [4];
   logic [PM_W:0]   sel     [4];
   logic [PM_W-1:0] new_pm  [4];
   logic [3:0]      dec_d;
   logic            all_high;
   logic [1:0]      best_d;
   logic [PM_W-1:0] best_val;
   logic [3:0]      dec_q;
   logic [1:0]      best_q;
   logic            valid_q;

   function automatic logic [PM_W:0] ext_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
      return {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         old_pm[i] = pm_q[i];
         if (i_start) old_pm[i] = (i == 0) ? '0 : INIT;
      end

      // Predecessors of ns are {ns[0],0} and {ns[0],1}; the branch metric is the
      // codeword {u^s1^s0, u^s0} emitted on that transition.
      cand0[0] = ext_add(old_pm[0], i_BM_0);
      cand1[0] = ext_add(old_pm[1], i_BM_3);
      cand0[1] = ext_add(old_pm[2], i_BM_2);
      cand1[1] = ext_add(old_pm[3], i_BM_1);
      cand0[2] = ext_add(old_pm[0], i_BM_3);
      cand1[2] = ext_add(old_pm[1], i_BM_0);
      cand0[3] = ext_add(old_pm[2], i_BM_1);
      cand1[3] = ext_add(old_pm[3], i_BM_2);

      all_high = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dec_d[i] = (cand1[i] < cand0[i]);
         sel[i]   = dec_d[i] ? cand1[i] : cand0[i];
         if (sel[i] < HALF) all_high = 1'b0;
      end

      for (int i = 0; i < 4; i++) begin
         new_pm[i] = all_high ? PM_W'(sel[i] - HALF) : sel[i][PM_W-1:0];
      end

      // Strict compare keeps the lowest index on ties.
      best_d   = 2'd0;
      best_val = new_pm[0];
      for (int i = 1; i < 4; i++) begin
         if (new_pm[i] < best_val) begin
            best_d   = 2'(i);
            best_val = new_pm[i];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pm_q[0] <= '0;
         pm_q[1] <= INIT;
         pm_q[2] <= INIT;
         pm_q[3] <= INIT;
         dec_q   <= '0;
         best_q  <= '0;
         valid_q <= 1'b0;
      end else if (i_valid) begin
         for (int i = 0; i < 4; i++) pm_q[i] <= new_pm[i];
         dec_q   <= dec_d;
         best_q  <= best_d;
         valid_q <= 1'b1;
      end else if (i_start) begin
         pm_q[0] <= '0;
         pm_q[1] <= INIT;
         pm_q[2] <= INIT;
         pm_q[3] <= INIT;
         dec_q   <= '0;
         best_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign o_valid      = valid_q;
   assign o_dec        = dec_q;
   assign o_best_state = best_q;
   assign o_PM_0       = pm_q[0];
   assign o_PM_1       = pm_q[1];
   assign o_PM_2       = pm_q[2];
   assign o_PM_3       = pm_q[3];

endmodule

// File: tb/tb_acs_path_metric_unit.sv
// Bench for acs_path_metric_unit: trellis-level reference model, expected-output
// queue, directed corner cases and a long randomized run with a mid-frame reset.
module tb_acs_path_metric_unit;

   localparam int PM_W    = 6;
   localparam int PM_INIT = 4;
   localparam int HALF    = 1 << (PM_W - 1);
   localparam int EW      = 1 + 4 + 2 + 4 * PM_W;

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b1;
   logic            i_start = 1'b0;
   logic            i_valid = 1'b0;
   logic [1:0]      i_BM_0 = '0;
   logic [1:0]      i_BM_1 = '0;
   logic [1:0]      i_BM_2 = '0;
   logic [1:0]      i_BM_3 = '0;
   logic            o_valid;
   logic [3:0]      o_dec;
   logic [PM_W-1:0] o_PM_0, o_PM_1, o_PM_2, o_PM_3;
   logic [1:0]      o_best_state;

   acs_path_metric_unit #(.PM_W(PM_W), .PM_INIT(PM_INIT)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid),
      .i_BM_0(i_BM_0), .i_BM_1(i_BM_1), .i_BM_2(i_BM_2), .i_BM_3(i_BM_3),
      .o_valid(o_valid), .o_dec(o_dec),
      .o_PM_0(o_PM_0), .o_PM_1(o_PM_1), .o_PM_2(o_PM_2), .o_PM_3(o_PM_3),
      .o_best_state(o_best_state)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [EW-1:0] exp_q[$];

   // reference model state: bounded (renormalised) and unbounded metrics
   int         m_pm[4];
   int         u_pm[4];
   logic [3:0] m_dec;
   int         m_best;
   logic       m_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pm    = '{0, PM_INIT, PM_INIT, PM_INIT};
      u_pm    = '{0, PM_INIT, PM_INIT, PM_INIT};
      m_dec   = '0;
      m_best  = 0;
      m_valid = 1'b0;
   endtask

   // Trellis ACS derived from the encoder: input u, state s={s1,s0}, codeword {c0,c1}.
   task automatic model_step(input bit v, input bit st, input int bm[4]);
      int old_b[4], old_u[4], nb[4], nu[4];
      int cb[2], cu[2];
      bit all_high;
      if (v) begin
         old_b = st ? '{0, PM_INIT, PM_INIT, PM_INIT} : m_pm;
         old_u = st ? '{0, PM_INIT, PM_INIT, PM_INIT} : u_pm;
         for (int ns = 0; ns < 4; ns++) begin
            int u;
            u = ns >> 1;
            for (int k = 0; k < 2; k++) begin
               int p, s1, s0, c0, c1;
               p  = ((ns & 1) << 1) | k;
               s1 = p >> 1;
               s0 = p & 1;
               c0 = u ^ s1 ^ s0;
               c1 = u ^ s0;
               cb[k] = old_b[p] + bm[c0 * 2 + c1];
               cu[k] = old_u[p] + bm[c0 * 2 + c1];
            end
            m_dec[ns] = (cb[1] < cb[0]);
            nb[ns] = (cb[1] < cb[0]) ? cb[1] : cb[0];
            nu[ns] = (cu[1] < cu[0]) ? cu[1] : cu[0];
         end
         all_high = 1'b1;
         for (int i = 0; i < 4; i++) if (nb[i] < HALF) all_high = 1'b0;
         for (int i = 0; i < 4; i++) m_pm[i] = all_high ? nb[i] - HALF : nb[i];
         u_pm = nu;
         m_best = 0;
         for (int i = 1; i < 4; i++) if (m_pm[i] < m_pm[m_best]) m_best = i;
         m_valid = 1'b1;
      end else if (st) begin
         model_reset();
      end else begin
         m_valid = 1'b0;
      end
   endtask

   task automatic expect_push();
      exp_q.push_back({m_valid, m_dec, 2'(m_best),
                       PM_W'(m_pm[3]), PM_W'(m_pm[2]), PM_W'(m_pm[1]), PM_W'(m_pm[0])});
   endtask

   task automatic compare_outputs();
      logic [EW-1:0] e;
      logic [PM_W-1:0] dp[4];
      dp = '{o_PM_0, o_PM_1, o_PM_2, o_PM_3};
      if (exp_q.size() == 0) begin
         check("exp_queue_empty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check("o_valid", o_valid, e[EW-1]);
      check("o_dec", o_dec, e[EW-2 -: 4]);
      check("o_best_state", o_best_state, e[EW-6 -: 2]);
      check("o_PM_0", o_PM_0, e[0*PM_W +: PM_W]);
      check("o_PM_1", o_PM_1, e[1*PM_W +: PM_W]);
      check("o_PM_2", o_PM_2, e[2*PM_W +: PM_W]);
      check("o_PM_3", o_PM_3, e[3*PM_W +: PM_W]);
      for (int i = 1; i < 4; i++)
         check("pm_diff_vs_unbounded", int'(dp[i]) - int'(dp[0]), u_pm[i] - u_pm[0]);
   endtask

   // driver: apply one cycle of inputs, then compare just after the edge
   task automatic step(input bit v, input bit st, input int bm[4]);
      @(negedge i_clk);
      i_valid = v;
      i_start = st;
      i_BM_0  = 2'(bm[0]);
      i_BM_1  = 2'(bm[1]);
      i_BM_2  = 2'(bm[2]);
      i_BM_3  = 2'(bm[3]);
      model_step(v, st, bm);
      expect_push();
      @(posedge i_clk);
      #1;
      compare_outputs();
   endtask

   // asserts reset between clock edges and checks it takes effect without an edge
   task automatic do_reset();
      #2;
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_start = 1'b0;
      #1;
      model_reset();
      exp_q.delete();
      check("rst_valid", o_valid, m_valid);
      check("rst_dec", o_dec, m_dec);
      check("rst_best", o_best_state, 2'(m_best));
      check("rst_pm0", o_PM_0, PM_W'(m_pm[0]));
      check("rst_pm1", o_PM_1, PM_W'(m_pm[1]));
      check("rst_pm2", o_PM_2, PM_W'(m_pm[2]));
      check("rst_pm3", o_PM_3, PM_W'(m_pm[3]));
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   function automatic int dut_min();
      int m;
      m = int'(o_PM_0);
      if (int'(o_PM_1) < m) m = int'(o_PM_1);
      if (int'(o_PM_2) < m) m = int'(o_PM_2);
      if (int'(o_PM_3) < m) m = int'(o_PM_3);
      return m;
   endfunction

   function automatic void rand_bm(output int b[4]);
      for (int k = 0; k < 4; k++) b[k] = $urandom_range(0, 3);
   endfunction

   initial begin
      int b[4];
      int pulses;
      int prev_min;
      bit norm_seen;

      // received 00 twice, straight after reset
      do_reset();
      step(1, 0, '{0, 1, 1, 2});
      check("r00_pm1_const", o_PM_1, 5);
      check("r00_pm2_const", o_PM_2, 2);
      step(1, 0, '{0, 1, 1, 2});
      check("r00b_pm1_const", o_PM_1, 3);

      // received 11: ties on ns1/ns3 must choose the lower predecessor
      do_reset();
      step(1, 0, '{2, 1, 1, 0});
      check("r11_dec_const", o_dec, 0);
      check("r11_best_const", o_best_state, 2);

      // stall: valid, three idle cycles, valid
      do_reset();
      pulses = 0;
      rand_bm(b); step(1, 0, b); if (o_valid) pulses++;
      for (int i = 0; i < 3; i++) begin
         rand_bm(b); step(0, 0, b); if (o_valid) pulses++;
      end
      rand_bm(b); step(1, 0, b); if (o_valid) pulses++;
      rand_bm(b); step(0, 0, b); if (o_valid) pulses++;
      check("stall_pulses", pulses, 2);

      // normalisation: all BMs at 3, the minimum can only fall by renormalising
      do_reset();
      norm_seen = 1'b0;
      prev_min = dut_min();
      for (int i = 0; i < 40; i++) begin
         step(1, 0, '{3, 3, 3, 3});
         if (dut_min() < prev_min) norm_seen = 1'b1;
         prev_min = dut_min();
      end
      check("norm_seen", norm_seen, 1);

      // frame start colliding with a valid symbol, then start alone
      do_reset();
      for (int i = 0; i < 5; i++) begin
         rand_bm(b); step(1, 0, b);
      end
      step(1, 1, '{0, 1, 1, 2});
      check("start_col_pm1_const", o_PM_1, 5);
      check("start_col_pm3_const", o_PM_3, 5);
      rand_bm(b); step(1, 0, b);
      rand_bm(b); step(0, 1, b);
      check("start_only_valid_const", o_valid, 0);
      check("start_only_pm2_const", o_PM_2, PM_INIT);

      // long random run with an asynchronous reset mid-frame
      do_reset();
      for (int n = 0; n < 1000; n++) begin
         bit v, st;
         v  = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 49) == 0);
         rand_bm(b);
         step(v, st, b);
         if (n == 500) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
